// File: rtl/fpu_pkg.sv
// Shared types for the FPU sharing blocks: adder tag layout, request bundle and arbiter states.
package fpu_pkg;

    localparam int unsigned ADDER_ID_W   = 2;
    localparam int unsigned ADDER_UTAG_W = 6;

    typedef struct packed {
        logic [63:0]             a;
        logic [63:0]             b;
        logic [ADDER_UTAG_W-1:0] utag;
        logic [63:0]             mult_operand;
    } adder_req_t;

    // Adder tag carries the requester index above the user tag.
    typedef struct packed {
        logic [ADDER_ID_W-1:0]   id;
        logic [ADDER_UTAG_W-1:0] utag;
    } adder_tag_t;

    typedef enum logic [0:0] {
        StRun,
        StDrain
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first eligible index after the pointer.
module rr_arbiter #(
    parameter int unsigned N = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N-1:0]         eligible_i,
    input  logic                 advance_i,
    output logic [N-1:0]         grant_o,
    output logic [$clog2(N)-1:0] ptr_o
);

    localparam int unsigned PtrW = $clog2(N);

    logic [PtrW-1:0] ptr_q, ptr_d;
    logic [PtrW-1:0] cand_idx;
    int unsigned     cand;

    always_comb begin
        grant_o  = '0;
        ptr_d    = ptr_q;
        cand     = 0;
        cand_idx = '0;
        for (int k = 1; k <= int'(N); k++) begin
            cand     = (int'(ptr_q) + k) % int'(N);
            cand_idx = PtrW'(cand);
            if (advance_i && (grant_o == '0) && eligible_i[cand_idx]) begin
                grant_o[cand_idx] = 1'b1;
                ptr_d             = cand_idx;
            end
        end
    end

    // Next-state pointer: equals the granted index whenever a grant is made.
    assign ptr_o = ptr_d;

    always_ff @(posedge clock) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/double_adder_arbiter.sv
// Shares one pipelined double adder among NUM_REQ requesters with credits, routing and drain.
module double_adder_arbiter
    import fpu_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = ADDER_ID_W,
    parameter int unsigned UTAG_W  = ADDER_UTAG_W,
    parameter int unsigned MAX_OUT = 7
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*64-1:0]     req_a,
    input  logic [NUM_REQ*64-1:0]     req_b,
    input  logic [NUM_REQ*UTAG_W-1:0] req_utag,
    input  logic [NUM_REQ*64-1:0]     req_mult_operand,
    output logic                      adder_valid,
    output logic [63:0]               adder_a,
    output logic [63:0]               adder_b,
    output logic [ID_W+UTAG_W-1:0]    adder_tag,
    output logic [63:0]               adder_mult_operand,
    input  logic                      adder_stall,
    input  logic                      res_valid,
    input  logic [63:0]               res_z,
    input  logic [ID_W+UTAG_W-1:0]    res_tag,
    input  logic [63:0]               res_mult_operand,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [63:0]               rsp_z,
    output logic [UTAG_W-1:0]         rsp_utag,
    output logic [63:0]               rsp_mult_operand,
    input  logic                      flush_req,
    output logic                      flush_done,
    output logic                      busy,
    output logic                      err_sticky
);

    localparam int unsigned TagW = ID_W + UTAG_W;
    localparam int unsigned CntW = $clog2(MAX_OUT + 1);

    arb_state_e state_q, state_d;

    logic [NUM_REQ-1:0] eligible, grant;
    logic [ID_W-1:0]    gnt_id;
    logic               can_load, any_grant, any_cnt;

    logic               slot_valid_q, slot_valid_d;
    logic [63:0]        slot_a_q, slot_a_d, slot_b_q, slot_b_d, slot_mop_q, slot_mop_d;
    logic [TagW-1:0]    slot_tag_q, slot_tag_d;

    logic [CntW-1:0]    cnt_q [NUM_REQ];
    logic [CntW-1:0]    cnt_d [NUM_REQ];

    logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [63:0]        rsp_z_q, rsp_z_d, rsp_mop_q, rsp_mop_d;
    logic [UTAG_W-1:0]  rsp_utag_q, rsp_utag_d;
    logic [ID_W-1:0]    res_id;
    logic               res_id_ok;

    logic               err_q, err_d, flush_done_q, flush_done_d;

    // The slot may take a new request if empty or if the adder consumes it this cycle.
    assign can_load  = !slot_valid_q || !adder_stall;
    assign any_grant = |grant;
    assign req_ready = grant;

    always_comb begin
        eligible = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            eligible[i] = req_valid[i] && (cnt_q[i] < CntW'(MAX_OUT)) &&
                          (state_q == StRun) && !reset;
        end
    end

    rr_arbiter #(
        .N(NUM_REQ)
    ) u_rr_arbiter (
        .clock     (clock),
        .reset     (reset),
        .eligible_i(eligible),
        .advance_i (can_load),
        .grant_o   (grant),
        .ptr_o     (gnt_id)
    );

    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_a_d     = slot_a_q;
        slot_b_d     = slot_b_q;
        slot_tag_d   = slot_tag_q;
        slot_mop_d   = slot_mop_q;
        if (can_load) begin
            slot_valid_d = any_grant;
            if (any_grant) begin
                slot_a_d   = req_a[int'(gnt_id)*64 +: 64];
                slot_b_d   = req_b[int'(gnt_id)*64 +: 64];
                slot_mop_d = req_mult_operand[int'(gnt_id)*64 +: 64];
                slot_tag_d = {gnt_id, req_utag[int'(gnt_id)*UTAG_W +: UTAG_W]};
            end
        end
    end

    assign res_id    = res_tag[TagW-1 -: ID_W];
    assign res_id_ok = ({1'b0, res_id} < (ID_W + 1)'(NUM_REQ));

    always_comb begin
        rsp_valid_d = '0;
        rsp_z_d     = rsp_z_q;
        rsp_utag_d  = rsp_utag_q;
        rsp_mop_d   = rsp_mop_q;
        if (res_valid) begin
            rsp_z_d    = res_z;
            rsp_utag_d = res_tag[UTAG_W-1:0];
            rsp_mop_d  = res_mult_operand;
            if (res_id_ok) begin
                rsp_valid_d[res_id] = 1'b1;
            end
        end
    end

    // Credits return when the response strobe is delivered to the requester.
    always_comb begin
        err_d   = err_q;
        any_cnt = 1'b0;
        if (res_valid && !res_id_ok) begin
            err_d = 1'b1;
        end
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            cnt_d[i] = cnt_q[i];
            any_cnt  = any_cnt || (cnt_q[i] != '0);
            if (rsp_valid_q[i] && (cnt_q[i] == '0)) begin
                err_d = 1'b1;
            end
            if (grant[i] && !rsp_valid_q[i]) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end else if (!grant[i] && rsp_valid_q[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    assign busy = slot_valid_q || any_cnt;

    always_comb begin
        state_d      = state_q;
        flush_done_d = 1'b0;
        unique case (state_q)
            StRun: begin
                if (flush_req) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (!busy) begin
                    state_d      = StRun;
                    flush_done_d = 1'b1;
                end
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StRun;
            slot_valid_q <= 1'b0;
            slot_a_q     <= '0;
            slot_b_q     <= '0;
            slot_tag_q   <= '0;
            slot_mop_q   <= '0;
            rsp_valid_q  <= '0;
            rsp_z_q      <= '0;
            rsp_utag_q   <= '0;
            rsp_mop_q    <= '0;
            err_q        <= 1'b0;
            flush_done_q <= 1'b0;
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            slot_valid_q <= slot_valid_d;
            slot_a_q     <= slot_a_d;
            slot_b_q     <= slot_b_d;
            slot_tag_q   <= slot_tag_d;
            slot_mop_q   <= slot_mop_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_z_q      <= rsp_z_d;
            rsp_utag_q   <= rsp_utag_d;
            rsp_mop_q    <= rsp_mop_d;
            err_q        <= err_d;
            flush_done_q <= flush_done_d;
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign adder_valid        = slot_valid_q;
    assign adder_a            = slot_a_q;
    assign adder_b            = slot_b_q;
    assign adder_tag          = slot_tag_q;
    assign adder_mult_operand = slot_mop_q;
    assign rsp_valid          = rsp_valid_q;
    assign rsp_z              = rsp_z_q;
    assign rsp_utag           = rsp_utag_q;
    assign rsp_mult_operand   = rsp_mop_q;
    assign flush_done         = flush_done_q;
    assign err_sticky         = err_q;

endmodule

// File: tb/tb_double_adder_arbiter.sv
// Directed bench for double_adder_arbiter: reset, fairness, stall hold, credits, routing, flush.
module tb_double_adder_arbiter;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned ID_W    = 2;
    localparam int unsigned UTAG_W  = 6;
    localparam int unsigned TAG_W   = ID_W + UTAG_W;

    logic                      clock = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*64-1:0]     req_a, req_b, req_mult_operand;
    logic [NUM_REQ*UTAG_W-1:0] req_utag;
    logic                      adder_valid;
    logic [63:0]               adder_a, adder_b, adder_mult_operand;
    logic [TAG_W-1:0]          adder_tag;
    logic                      adder_stall;
    logic                      res_valid;
    logic [63:0]               res_z, res_mult_operand;
    logic [TAG_W-1:0]          res_tag;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [63:0]               rsp_z, rsp_mult_operand;
    logic [UTAG_W-1:0]         rsp_utag;
    logic                      flush_req, flush_done, busy, err_sticky;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    double_adder_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ID_W   (ID_W),
        .UTAG_W (UTAG_W),
        .MAX_OUT(7)
    ) dut (
        .clock             (clock),
        .reset             (reset),
        .req_valid         (req_valid),
        .req_ready         (req_ready),
        .req_a             (req_a),
        .req_b             (req_b),
        .req_utag          (req_utag),
        .req_mult_operand  (req_mult_operand),
        .adder_valid       (adder_valid),
        .adder_a           (adder_a),
        .adder_b           (adder_b),
        .adder_tag         (adder_tag),
        .adder_mult_operand(adder_mult_operand),
        .adder_stall       (adder_stall),
        .res_valid         (res_valid),
        .res_z             (res_z),
        .res_tag           (res_tag),
        .res_mult_operand  (res_mult_operand),
        .rsp_valid         (rsp_valid),
        .rsp_z             (rsp_z),
        .rsp_utag          (rsp_utag),
        .rsp_mult_operand  (rsp_mult_operand),
        .flush_req         (flush_req),
        .flush_done        (flush_done),
        .busy              (busy),
        .err_sticky        (err_sticky)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        req_valid        = '0;
        adder_stall      = 1'b0;
        res_valid        = 1'b0;
        res_tag          = '0;
        res_z            = '0;
        res_mult_operand = '0;
        flush_req        = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        req_valid = '1;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            req_a[i*64 +: 64]            = 64'h4000_0000_0000_0000 | 64'(i);
            req_b[i*64 +: 64]            = 64'h3FF0_0000_0000_0000 | 64'(i);
            req_mult_operand[i*64 +: 64] = 64'h00AB_CD00 + 64'(i);
            req_utag[i*UTAG_W +: UTAG_W] = 6'(16 + i);
        end

        // Reset held with every requester asking.
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("reset_outs", 64'({req_ready, adder_valid, rsp_valid, busy, flush_done, err_sticky}),
                64'h0);
        end
        reset = 1'b0;

        // Fairness: grants 1,2,3,0,1,... and the issued tag follows one cycle later.
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("fair_ready", 64'(req_ready), 64'(4'b0001 << ((k + 1) % 4)));
            if (k > 0) begin
                chk("fair_tag", 64'(adder_tag), 64'({2'((k % 4)), 6'(16 + (k % 4))}));
                chk("fair_a", adder_a, 64'h4000_0000_0000_0000 | 64'(k % 4));
            end
            tick();
        end

        // Stall hold with 1.5 + 2.25 from requester 2.
        do_reset();
        req_valid            = 4'b0100;
        req_a[2*64 +: 64]    = 64'h3FF8_0000_0000_0000;
        req_b[2*64 +: 64]    = 64'h4002_0000_0000_0000;
        #1;
        chk("stall_grant", 64'(req_ready), 64'h4);
        tick();
        req_valid   = 4'b1111;
        adder_stall = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #1;
            chk("stall_valid", 64'(adder_valid), 64'h1);
            chk("stall_a", adder_a, 64'h3FF8_0000_0000_0000);
            chk("stall_b", adder_b, 64'h4002_0000_0000_0000);
            chk("stall_tag", 64'(adder_tag), 64'({2'd2, 6'd18}));
            chk("stall_ready", 64'(req_ready), 64'h0);
            tick();
        end
        adder_stall = 1'b0;
        #1;
        chk("stall_resume", 64'(req_ready), 64'h8);
        tick();
        #1;
        chk("stall_next_tag", 64'(adder_tag), 64'({2'd3, 6'd19}));

        // Credits: seven grants to requester 0, then blocked until one result returns.
        do_reset();
        req_valid = 4'b0001;
        for (int k = 0; k < 9; k++) begin
            #1;
            chk("credit_ready", 64'(req_ready), 64'(k < 7));
            tick();
        end
        res_valid = 1'b1;
        res_tag   = {2'd0, 6'h05};
        res_z     = 64'h4010_0000_0000_0000;
        #1;
        chk("credit_wait", 64'(req_ready), 64'h0);
        tick();
        res_valid = 1'b0;
        #1;
        chk("credit_rsp", 64'(rsp_valid), 64'h1);
        chk("credit_still_blocked", 64'(req_ready), 64'h0);
        tick();
        #1;
        chk("credit_resume", 64'(req_ready), 64'h1);
        chk("credit_err", 64'(err_sticky), 64'h0);
        tick();
        #1;
        chk("credit_reblocked", 64'(req_ready), 64'h0);
        chk("credit_busy", 64'(busy), 64'h1);

        // Routing to requester 3, which has nothing outstanding.
        do_reset();
        res_valid        = 1'b1;
        res_tag          = {2'd3, 6'h2A};
        res_z            = 64'h400E_0000_0000_0000;
        res_mult_operand = 64'h0000_1111_2222_3333;
        #1;
        chk("route_err_pre", 64'(err_sticky), 64'h0);
        tick();
        res_valid = 1'b0;
        #1;
        chk("route_valid", 64'(rsp_valid), 64'h8);
        chk("route_utag", 64'(rsp_utag), 64'h2A);
        chk("route_z", rsp_z, 64'h400E_0000_0000_0000);
        chk("route_mop", rsp_mult_operand, 64'h0000_1111_2222_3333);
        tick();
        #1;
        chk("route_pulse", 64'(rsp_valid), 64'h0);
        chk("err_set", 64'(err_sticky), 64'h1);
        chk("err_busy", 64'(busy), 64'h0);
        tick();
        tick();
        #1;
        chk("err_sticky_hold", 64'(err_sticky), 64'h1);

        // Flush with two adds outstanding.
        do_reset();
        req_valid = 4'b0011;
        #1;
        chk("flush_g1", 64'(req_ready), 64'h2);
        tick();
        flush_req = 1'b1;
        #1;
        chk("flush_same_cycle_grant", 64'(req_ready), 64'h1);
        tick();
        for (int c = 2; c <= 9; c++) begin
            flush_req = (c == 2);
            res_valid = (c == 6) || (c == 7);
            res_tag   = (c == 6) ? {2'd1, 6'd0} : {2'd0, 6'd0};
            #1;
            chk("drain_ready", 64'(req_ready), 64'h0);
            chk("drain_done_low", 64'(flush_done), 64'h0);
            chk("drain_busy", 64'(busy), 64'(c < 9));
            tick();
        end
        res_valid = 1'b0;
        #1;
        chk("flush_done_pulse", 64'(flush_done), 64'h1);
        chk("flush_run_grant", 64'(req_ready), 64'h2);
        tick();
        req_valid = '0;
        #1;
        chk("flush_done_clear", 64'(flush_done), 64'h0);
        chk("flush_err", 64'(err_sticky), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
